ifu_lsu_arbiter: RTL and testbench

- Shares the single core memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of rv_percpu.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block allows one outstanding transaction at a time, breaks ties round-robin, and holds the grant until the owner accepts its response.
- It sits between the core front end, the LSU and the memory/bus adapter.

---
 rtl/ifu_lsu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ifu_lsu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_lsu_arbiter.sv
// Shares one memory port between IFU and LSU with one outstanding transaction.
// Round-robin on ties; the grant is held until the owner accepts its response.
module ifu_lsu_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_busy;
    logic                  r_mem_req_valid;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wmask;

    logic w_idle;
    logic w_resp;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_ifu_hs;
    logic w_lsu_hs;
    logic w_owner_rdy;
    logic w_resp_hs;

    assign w_idle = (r_state == IDLE);
    assign w_resp = (r_state == RESP);

    // r_last_grant: 0 = IFU, 1 = LSU; the other side wins a tie
    assign w_grant_ifu = ifu_req_valid
                       && (!lsu_req_valid || r_last_grant);
    assign w_grant_lsu = lsu_req_valid
                       && (!ifu_req_valid || !r_last_grant);

    assign ifu_req_ready = w_idle && w_grant_ifu;
    assign lsu_req_ready = w_idle && w_grant_lsu;

    assign w_ifu_hs = ifu_req_ready && ifu_req_valid;
    assign w_lsu_hs = lsu_req_ready && lsu_req_valid;

    assign w_owner_rdy = r_owner ? lsu_resp_ready : ifu_resp_ready;

    // IDLE accepts and drops stray responses to drain the slave
    always_comb begin
        mem_resp_ready = 1'b0;
        if (w_idle) begin
            mem_resp_ready = 1'b1;
        end else if (w_resp) begin
            mem_resp_ready = w_owner_rdy;
        end
    end

    assign w_resp_hs = w_resp && mem_resp_valid && w_owner_rdy;

    assign ifu_resp_valid = w_resp && !r_owner && mem_resp_valid;
    assign lsu_resp_valid = w_resp && r_owner && mem_resp_valid;
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;
    assign busy          = r_busy;
    assign owner         = r_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_last_grant    <= 1'b1;
            r_owner         <= 1'b0;
            r_busy          <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_addr          <= '0;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wmask         <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_ifu_hs) begin
                        r_addr          <= ifu_addr;
                        r_wen           <= 1'b0;
                        r_wdata         <= '0;
                        r_wmask         <= '0;
                        r_owner         <= 1'b0;
                        r_last_grant    <= 1'b0;
                        r_busy          <= 1'b1;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end else if (w_lsu_hs) begin
                        r_addr          <= lsu_addr;
                        r_wen           <= lsu_wen;
                        r_wdata         <= lsu_wdata;
                        r_wmask         <= lsu_wmask;
                        r_owner         <= 1'b1;
                        r_last_grant    <= 1'b1;
                        r_busy          <= 1'b1;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= RESP;
                    end
                end
                RESP: begin
                    if (w_resp_hs) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy          <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                    r_state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_lsu_arbiter.sv
// Directed bench for ifu_lsu_arbiter: fetch, store, round-robin,
// response stall, mid-operation reset and idle behaviour.
module tb_ifu_lsu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifu_lsu_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .owner          (owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        lsu_resp_ready = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_mreqv", mem_req_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mwdata", mem_wdata, 0);
        chk("rst_ifu_rdy", ifu_req_ready, 0);

        // IFU fetch, memory ready after 2 cycles
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        #1;
        chk("f_ifu_rdy", ifu_req_ready, 1);
        chk("f_lsu_rdy", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h1234_5678;
        chk("f_mreqv", mem_req_valid, 1);
        chk("f_maddr", mem_addr, 32'h8000_0000);
        chk("f_mwen", mem_wen, 0);
        chk("f_busy", busy, 1);
        chk("f_mrr_req", mem_resp_ready, 0);
        tick();
        chk("f_mreqv_hold", mem_req_valid, 1);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0413;
        ifu_resp_ready = 1'b1;
        #1;
        chk("f_mreqv_off", mem_req_valid, 0);
        chk("f_ifu_rv", ifu_resp_valid, 1);
        chk("f_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("f_lsu_rv", lsu_resp_valid, 0);
        chk("f_mrr", mem_resp_ready, 1);
        tick();
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        chk("f_idle", busy, 0);

        // LSU store; data changed after handshake must not leak
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        #1;
        chk("s_lsu_rdy", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_wdata     = 32'h1234_5678;
        lsu_wmask     = 4'h1;
        lsu_wen       = 1'b0;
        chk("s_mwen", mem_wen, 1);
        chk("s_maddr", mem_addr, 32'h8000_1000);
        chk("s_mwdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s_mwmask", mem_wmask, 4'hF);
        chk("s_owner", owner, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        lsu_resp_ready = 1'b1;
        #1;
        chk("s_mwdata_keep", mem_wdata, 32'hDEAD_BEEF);
        chk("s_lsu_rv", lsu_resp_valid, 1);
        chk("s_ifu_rv", ifu_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        lsu_resp_ready = 1'b0;
        chk("s_idle", busy, 0);

        // Round-robin after reset with both requesters always valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0100;
        lsu_addr       = 32'h8000_2000;
        lsu_wen        = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d_ifu_rdy", i), ifu_req_ready,
                (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_lsu_rdy", i), lsu_req_ready,
                (i % 2 == 0) ? 0 : 1);
            tick();
            chk($sformatf("rr%0d_owner", i), owner,
                (i % 2 == 0) ? 0 : 1);
            tick();
            tick();
        end
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        tick();

        // Response stall: owner withholds resp_ready for 5 cycles
        ifu_req_valid = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_0001;
        lsu_req_valid  = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("st%0d_mrr", i), mem_resp_ready, 0);
            chk($sformatf("st%0d_busy", i), busy, 1);
            chk($sformatf("st%0d_lsu_rdy", i), lsu_req_ready, 0);
            tick();
        end
        ifu_resp_ready = 1'b1;
        #1;
        chk("st_mrr_go", mem_resp_ready, 1);
        chk("st_ifu_rdata", ifu_rdata, 32'hCAFE_0001);
        tick();
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        chk("st_lsu_grant", lsu_req_ready, 1);
        lsu_req_valid = 1'b0;
        tick();
        chk("wd_busy", busy, 0);
        chk("wd_mreqv", mem_req_valid, 0);

        // Reset in REQ; later stray response is absorbed
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0200;
        tick();
        ifu_req_valid = 1'b0;
        chk("mr_mreqv", mem_req_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_mreqv_off", mem_req_valid, 0);
        chk("mr_busy", busy, 0);
        mem_resp_valid = 1'b1;
        ifu_resp_ready = 1'b1;
        #1;
        chk("mr_ifu_rv", ifu_resp_valid, 0);
        chk("mr_mrr", mem_resp_ready, 1);
        tick();
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;

        // Idle for 10 cycles
        repeat (10) tick();
        chk("id_busy", busy, 0);
        chk("id_mreqv", mem_req_valid, 0);
        chk("id_ifu_rdy", ifu_req_ready, 0);
        chk("id_lsu_rdy", lsu_req_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
